mem_access_unit: RTL and testbench

Multi-cycle load/store unit for the MIPS pipeline MEM stage. It drives a request/acknowledge data bus with wait states, which replaces the single-cycle combinational memory stage. It generates byte enables and lane mapping for byte, half and word accesses, and handles sign/zero extension, alignment exceptions and bus timeout. It stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data bus between the memory access unit (master) and memory (slave).
//
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata
// and holds all of them stable until the slave answers with a one-cycle
// bus_ack. bus_rdata is valid in the same cycle as bus_ack. The master drops
// bus_req on the cycle after the ack, or after a timeout.
//
// Signals:
//   bus_req   request in flight           (master -> slave)
//   bus_we    1 = write, 0 = read          (master -> slave)
//   bus_addr  word-aligned byte address    (master -> slave)
//   bus_be    byte enables, bit i = [8i+7:8i]
//   bus_wdata write data, lane-replicated
//   bus_ack   transaction complete         (slave -> master)
//   bus_rdata read data, valid with ack    (slave -> master)
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_ack;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit for the MEM stage of the MIPS pipeline.
//
// Accepts one op at a time from EX (in_valid/in_ready), computes the
// effective address, and either passes NONE ops straight through, raises an
// alignment exception, or runs one request/acknowledge bus transaction.
// Results go to WB as a single-cycle out_valid pulse; the out_* fields hold
// their values between pulses.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready          op handshake from EX
//   in_op, in_base, in_offset  op code and address operands
//   in_store_data              store source (rt)
//   in_wb_en/addr/data         writeback fields from EX (data used for NONE)
//   stall                      high while a bus transaction is in flight
//   out_valid                  one-cycle result pulse to WB
//   out_wb_en/addr/data        writeback result
//   out_exc/code/bad_addr      exception: 1 misaligned load, 2 misaligned
//                              store, 3 bus timeout
//   dbg_state                  current FSM state (0 IDLE, 1 REQ)
//   bus                        master side of the memory bus
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter bit ALIGN_CHECK    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [15:0]           in_offset,
  input  logic [31:0]           in_store_data,
  input  logic                  in_wb_en,
  input  logic [4:0]            in_wb_addr,
  input  logic [31:0]           in_wb_data,
  output logic                  stall,
  output logic                  out_valid,
  output logic                  out_wb_en,
  output logic [4:0]            out_wb_addr,
  output logic [31:0]           out_wb_data,
  output logic                  out_exc,
  output logic [1:0]            out_exc_code,
  output logic [ADDR_WIDTH-1:0] out_bad_addr,
  output logic                  dbg_state,
  mem_access_unit_if.master     bus
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] EXC_LOAD    = 2'd1;
  localparam logic [1:0] EXC_STORE   = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  // Counter counts completed wait cycles; the timeout fires in the REQ cycle
  // where it equals TIMEOUT_CYCLES-1, so bus_req is high exactly
  // TIMEOUT_CYCLES cycles.
  localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t state_q, state_d;

  // ---------------- op decode on the input side ----------------
  logic [ADDR_WIDTH-1:0] ea;
  logic                  is_load, is_store, is_mem, is_signed;
  logic [1:0]            sz;
  logic                  misaligned;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  accept;

  assign ea = in_base + {{(ADDR_WIDTH-16){in_offset[15]}}, in_offset};

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    sz        = SZ_WORD;
    case (in_op)
      4'd1: begin is_load  = 1'b1; sz = SZ_BYTE; is_signed = 1'b1; end
      4'd2: begin is_load  = 1'b1; sz = SZ_BYTE; end
      4'd3: begin is_load  = 1'b1; sz = SZ_HALF; is_signed = 1'b1; end
      4'd4: begin is_load  = 1'b1; sz = SZ_HALF; end
      4'd5: begin is_load  = 1'b1; sz = SZ_WORD; end
      4'd6: begin is_store = 1'b1; sz = SZ_BYTE; end
      4'd7: begin is_store = 1'b1; sz = SZ_HALF; end
      4'd8: begin is_store = 1'b1; sz = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = ALIGN_CHECK && is_mem &&
                      (((sz == SZ_HALF) && ea[0]) ||
                       ((sz == SZ_WORD) && (ea[1:0] != 2'b00)));
  assign accept     = in_valid && in_ready;

  // lane = byte index into the 32-bit bus word (0 = [7:0]). For halves only
  // lane[1] matters: 1 selects the upper half. Ignoring ea[0] (and ea[1] for
  // words) is what forces alignment when ALIGN_CHECK = 0.
  always_comb begin
    lane  = 2'd0;
    be    = 4'b1111;
    wdata = in_store_data;
    case (sz)
      SZ_BYTE: begin
        lane  = BIG_ENDIAN ? ~ea[1:0] : ea[1:0];
        be    = 4'b0001 << lane;
        wdata = {4{in_store_data[7:0]}};
      end
      SZ_HALF: begin
        lane  = {(BIG_ENDIAN ? ~ea[1] : ea[1]), 1'b0};
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------- registered transaction ----------------
  logic                  ld_q, sgn_q, we_q, wb_en_q;
  logic [1:0]            sz_q, lane_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] ea_q;
  logic [4:0]            wb_addr_q;
  logic [CW-1:0]         cnt_q;
  logic                  timeout_hit;
  logic [31:0]           load_data;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_REQ) &&
                       !bus.bus_ack && (cnt_q == CW'(TO_LAST));

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (lane_q)
      2'd0:    b = bus.bus_rdata[7:0];
      2'd1:    b = bus.bus_rdata[15:8];
      2'd2:    b = bus.bus_rdata[23:16];
      default: b = bus.bus_rdata[31:24];
    endcase
    h = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (sz_q)
      SZ_BYTE: load_data = {{24{sgn_q & b[7]}}, b};
      SZ_HALF: load_data = {{16{sgn_q & h[15]}}, h};
      default: load_data = bus.bus_rdata;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mem && !misaligned) state_d = S_REQ;
      S_REQ:  if (bus.bus_ack || timeout_hit)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Bus fields are gated to zero outside REQ so idle and reset look clean.
  always_comb begin
    in_ready      = (state_q == S_IDLE);
    stall         = (state_q == S_REQ);
    bus.bus_req   = (state_q == S_REQ);
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = 4'b0000;
    bus.bus_wdata = 32'd0;
    if (state_q == S_REQ) begin
      bus.bus_we    = we_q;
      bus.bus_addr  = {ea_q[ADDR_WIDTH-1:2], 2'b00};
      bus.bus_be    = be_q;
      bus.bus_wdata = wdata_q;
    end
  end

  assign dbg_state = state_q;

  // ---------------- transaction capture and timeout counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q      <= 1'b0;
      sgn_q     <= 1'b0;
      we_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      sz_q      <= SZ_WORD;
      lane_q    <= 2'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      ea_q      <= '0;
      wb_addr_q <= 5'd0;
      cnt_q     <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
      if (accept && is_mem && !misaligned) begin
        ld_q      <= is_load;
        sgn_q     <= is_signed;
        we_q      <= is_store;
        wb_en_q   <= in_wb_en;
        sz_q      <= sz;
        lane_q    <= lane;
        be_q      <= be;
        wdata_q   <= wdata;
        ea_q      <= ea;
        wb_addr_q <= in_wb_addr;
      end
    end else if (!bus.bus_ack) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // ---------------- result to WB ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_wb_en    <= 1'b0;
      out_wb_addr  <= 5'd0;
      out_wb_data  <= 32'd0;
      out_exc      <= 1'b0;
      out_exc_code <= 2'd0;
      out_bad_addr <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state_q == S_IDLE && accept && !is_mem) begin
        out_valid    <= 1'b1;
        out_wb_en    <= in_wb_en;
        out_wb_addr  <= in_wb_addr;
        out_wb_data  <= in_wb_data;
        out_exc      <= 1'b0;
        out_exc_code <= 2'd0;
        out_bad_addr <= '0;
      end else if (state_q == S_IDLE && accept && misaligned) begin
        out_valid    <= 1'b1;
        out_wb_en    <= 1'b0;
        out_wb_addr  <= in_wb_addr;
        out_wb_data  <= 32'd0;
        out_exc      <= 1'b1;
        out_exc_code <= is_load ? EXC_LOAD : EXC_STORE;
        out_bad_addr <= ea;
      end else if (state_q == S_REQ && bus.bus_ack) begin
        out_valid    <= 1'b1;
        out_wb_en    <= ld_q & wb_en_q;
        out_wb_addr  <= wb_addr_q;
        out_wb_data  <= ld_q ? load_data : 32'd0;
        out_exc      <= 1'b0;
        out_exc_code <= 2'd0;
        out_bad_addr <= '0;
      end else if (timeout_hit) begin
        out_valid    <= 1'b1;
        out_wb_en    <= 1'b0;
        out_wb_addr  <= wb_addr_q;
        out_wb_data  <= 32'd0;
        out_exc      <= 1'b1;
        out_exc_code <= EXC_TIMEOUT;
        out_bad_addr <= ea_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Two instances:
//   d=0: BIG_ENDIAN=1, ALIGN_CHECK=1, TIMEOUT_CYCLES=4
//   d=1: BIG_ENDIAN=0, ALIGN_CHECK=0, TIMEOUT_CYCLES=0 (no timeout)
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus and observation ----------------
  logic        in_valid[2], in_ready[2], in_wb_en[2];
  logic [3:0]  in_op[2];
  logic [31:0] in_base[2], in_store_data[2], in_wb_data[2];
  logic [15:0] in_offset[2];
  logic [4:0]  in_wb_addr[2];
  logic        stall[2], out_valid[2], out_wb_en[2], out_exc[2], dbg_state[2];
  logic [4:0]  out_wb_addr[2];
  logic [31:0] out_wb_data[2], out_bad_addr[2];
  logic [1:0]  out_exc_code[2];
  logic        ack[2];
  logic [31:0] rdata[2];
  logic        b_req[2], b_we[2];
  logic [31:0] b_addr[2], b_wdata[2];
  logic [3:0]  b_be[2];

  mem_access_unit_if #(.ADDR_WIDTH(32)) bus0 ();
  mem_access_unit_if #(.ADDR_WIDTH(32)) bus1 ();

  assign bus0.bus_ack   = ack[0];
  assign bus0.bus_rdata = rdata[0];
  assign bus1.bus_ack   = ack[1];
  assign bus1.bus_rdata = rdata[1];
  assign b_req[0] = bus0.bus_req;   assign b_req[1] = bus1.bus_req;
  assign b_we[0]  = bus0.bus_we;    assign b_we[1]  = bus1.bus_we;
  assign b_addr[0] = bus0.bus_addr; assign b_addr[1] = bus1.bus_addr;
  assign b_be[0]  = bus0.bus_be;    assign b_be[1]  = bus1.bus_be;
  assign b_wdata[0] = bus0.bus_wdata; assign b_wdata[1] = bus1.bus_wdata;

  mem_access_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1), .ALIGN_CHECK(1'b1),
                    .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
    .in_base(in_base[0]), .in_offset(in_offset[0]),
    .in_store_data(in_store_data[0]), .in_wb_en(in_wb_en[0]),
    .in_wb_addr(in_wb_addr[0]), .in_wb_data(in_wb_data[0]),
    .stall(stall[0]), .out_valid(out_valid[0]), .out_wb_en(out_wb_en[0]),
    .out_wb_addr(out_wb_addr[0]), .out_wb_data(out_wb_data[0]),
    .out_exc(out_exc[0]), .out_exc_code(out_exc_code[0]),
    .out_bad_addr(out_bad_addr[0]), .dbg_state(dbg_state[0]), .bus(bus0)
  );

  mem_access_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0), .ALIGN_CHECK(1'b0),
                    .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
    .in_base(in_base[1]), .in_offset(in_offset[1]),
    .in_store_data(in_store_data[1]), .in_wb_en(in_wb_en[1]),
    .in_wb_addr(in_wb_addr[1]), .in_wb_data(in_wb_data[1]),
    .stall(stall[1]), .out_valid(out_valid[1]), .out_wb_en(out_wb_en[1]),
    .out_wb_addr(out_wb_addr[1]), .out_wb_data(out_wb_data[1]),
    .out_exc(out_exc[1]), .out_exc_code(out_exc_code[1]),
    .out_bad_addr(out_bad_addr[1]), .dbg_state(dbg_state[1]), .bus(bus1)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for exactly one cycle; returns 1 time unit after the
  // accepting edge.
  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] base,
                       input logic [15:0] off, input logic [31:0] sd,
                       input logic wb_en, input logic [4:0] wb_addr,
                       input logic [31:0] wb_data);
    in_op[d]         = op;
    in_base[d]       = base;
    in_offset[d]     = off;
    in_store_data[d] = sd;
    in_wb_en[d]      = wb_en;
    in_wb_addr[d]    = wb_addr;
    in_wb_data[d]    = wb_data;
    in_valid[d]      = 1'b1;
    tick();
    in_valid[d]      = 1'b0;
  endtask

  // Acks in the current cycle and returns just after the following edge.
  task automatic ack_now(input int d, input logic [31:0] data);
    ack[d]   = 1'b1;
    rdata[d] = data;
    tick();
    ack[d]   = 1'b0;
    rdata[d] = 32'h0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_op[d] = 4'd0; in_base[d] = 32'h0;
      in_offset[d] = 16'h0; in_store_data[d] = 32'h0; in_wb_en[d] = 1'b0;
      in_wb_addr[d] = 5'd0; in_wb_data[d] = 32'h0; ack[d] = 1'b0; rdata[d] = 32'h0;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready[0], 1);
    check("rst_stall", stall[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_bus_req", b_req[0], 0);
    check("rst_bus_be", b_be[0], 0);
    check("rst_wb_data", out_wb_data[0], 0);
    check("rst_dbg_state", dbg_state[0], 0);

    // bus_ack in IDLE is ignored
    ack[0] = 1'b1; rdata[0] = 32'hFFFF_FFFF;
    tick();
    ack[0] = 1'b0;
    check("idle_ack_valid", out_valid[0], 0);
    check("idle_ack_stall", stall[0], 0);

    // LB ea 0x1003, big endian, two wait cycles
    issue(0, 4'd1, 32'h1000, 16'h0003, 32'h0, 1'b1, 5'd5, 32'h0);
    check("lb_bus_req", b_req[0], 1);
    check("lb_bus_addr", b_addr[0], 32'h1000);
    check("lb_bus_be", b_be[0], 4'b0001);
    check("lb_bus_we", b_we[0], 0);
    check("lb_stall1", stall[0], 1);
    check("lb_in_ready", in_ready[0], 0);
    tick();
    check("lb_stall2", stall[0], 1);
    tick();
    check("lb_stall3", stall[0], 1);
    check("lb_no_early_valid", out_valid[0], 0);
    ack_now(0, 32'h1122_3380);
    check("lb_valid", out_valid[0], 1);
    check("lb_data", out_wb_data[0], 32'hFFFF_FF80);
    check("lb_wb_en", out_wb_en[0], 1);
    check("lb_wb_addr", out_wb_addr[0], 5'd5);
    check("lb_exc", out_exc[0], 0);
    check("lb_stall_done", stall[0], 0);
    check("lb_req_done", b_req[0], 0);
    tick();
    check("lb_pulse_once", out_valid[0], 0);
    check("lb_data_hold", out_wb_data[0], 32'hFFFF_FF80);

    // LHU ea 0x1002, big endian, ack in first REQ cycle
    issue(0, 4'd4, 32'h1000, 16'h0002, 32'h0, 1'b1, 5'd6, 32'h0);
    check("lhu_be_be", b_be[0], 4'b0011);
    ack_now(0, 32'hAABB_8001);
    check("lhu_be_valid", out_valid[0], 1);
    check("lhu_be_data", out_wb_data[0], 32'h0000_8001);

    // Same on the little-endian instance
    issue(1, 4'd4, 32'h1000, 16'h0002, 32'h0, 1'b1, 5'd6, 32'h0);
    check("lhu_le_be", b_be[1], 4'b1100);
    ack_now(1, 32'hAABB_8001);
    check("lhu_le_data", out_wb_data[1], 32'h0000_AABB);

    // LH sign extension, little-endian lower half
    issue(1, 4'd3, 32'h1000, 16'h0000, 32'h0, 1'b1, 5'd7, 32'h0);
    check("lh_le_be", b_be[1], 4'b0011);
    ack_now(1, 32'h1234_9ABC);
    check("lh_le_data", out_wb_data[1], 32'hFFFF_9ABC);

    // SH base 0x2000 offset 2, big endian
    issue(0, 4'd7, 32'h2000, 16'h0002, 32'h1234_ABCD, 1'b1, 5'd8, 32'h0);
    check("sh_we", b_we[0], 1);
    check("sh_be", b_be[0], 4'b0011);
    check("sh_wdata", b_wdata[0], 32'hABCD_ABCD);
    check("sh_addr", b_addr[0], 32'h2000);
    ack_now(0, 32'h0);
    check("sh_valid", out_valid[0], 1);
    check("sh_wb_en", out_wb_en[0], 0);

    // SB with negative offset, little endian: ea 0x2FFF
    issue(1, 4'd6, 32'h3000, 16'hFFFF, 32'h1234_565A, 1'b1, 5'd9, 32'h0);
    check("sb_addr", b_addr[1], 32'h2FFC);
    check("sb_be", b_be[1], 4'b1000);
    check("sb_wdata", b_wdata[1], 32'h5A5A_5A5A);
    ack_now(1, 32'h0);
    check("sb_valid", out_valid[1], 1);

    // LW ea 0x1001 with alignment checking
    issue(0, 4'd5, 32'h1000, 16'h0001, 32'h0, 1'b1, 5'd10, 32'h0);
    check("lw_mis_req", b_req[0], 0);
    check("lw_mis_ready", in_ready[0], 1);
    check("lw_mis_valid", out_valid[0], 1);
    check("lw_mis_exc", out_exc[0], 1);
    check("lw_mis_code", out_exc_code[0], 2'd1);
    check("lw_mis_bad", out_bad_addr[0], 32'h1001);
    check("lw_mis_wb_en", out_wb_en[0], 0);

    // SH ea 0x2003 misaligned store
    issue(0, 4'd7, 32'h2000, 16'h0003, 32'h0, 1'b1, 5'd11, 32'h0);
    check("sh_mis_code", out_exc_code[0], 2'd2);
    check("sh_mis_bad", out_bad_addr[0], 32'h2003);

    // LW ea 0x1001 without alignment checking: forced to 0x1000
    issue(1, 4'd5, 32'h1000, 16'h0001, 32'h0, 1'b1, 5'd12, 32'h0);
    check("lw_na_req", b_req[1], 1);
    check("lw_na_addr", b_addr[1], 32'h1000);
    check("lw_na_be", b_be[1], 4'b1111);
    ack_now(1, 32'hDEAD_BEEF);
    check("lw_na_exc", out_exc[1], 0);
    check("lw_na_data", out_wb_data[1], 32'hDEAD_BEEF);

    // SW never acked: timeout after exactly 4 request cycles
    issue(0, 4'd8, 32'h4000, 16'h0000, 32'hCAFE_F00D, 1'b1, 5'd13, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("to_req_high", b_req[0], 1);
      tick();
    end
    check("to_req_low", b_req[0], 0);
    check("to_valid", out_valid[0], 1);
    check("to_exc", out_exc[0], 1);
    check("to_code", out_exc_code[0], 2'd3);
    check("to_bad", out_bad_addr[0], 32'h4000);
    check("to_wb_en", out_wb_en[0], 0);
    check("to_ready", in_ready[0], 1);
    issue(0, 4'd0, 32'h0, 16'h0, 32'h0, 1'b1, 5'd14, 32'h0000_0077);
    check("after_to_valid", out_valid[0], 1);
    check("after_to_data", out_wb_data[0], 32'h77);
    check("after_to_exc", out_exc[0], 0);

    // Ack on the timeout cycle wins
    issue(0, 4'd5, 32'h5000, 16'h0000, 32'h0, 1'b1, 5'd15, 32'h0);
    tick();
    tick();
    tick();
    check("race_req", b_req[0], 1);
    ack_now(0, 32'h0BAD_F00D);
    check("race_valid", out_valid[0], 1);
    check("race_exc", out_exc[0], 0);
    check("race_data", out_wb_data[0], 32'h0BAD_F00D);

    // Op codes 9-15 behave as NONE
    issue(1, 4'd12, 32'h0, 16'h0, 32'h0, 1'b0, 5'd16, 32'h0000_0099);
    check("op12_valid", out_valid[1], 1);
    check("op12_data", out_wb_data[1], 32'h99);
    check("op12_wb_en", out_wb_en[1], 0);

    // Reset in the 2nd REQ cycle
    issue(0, 4'd5, 32'h6000, 16'h0000, 32'h0, 1'b1, 5'd17, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_req", b_req[0], 0);
    check("midrst_ready", in_ready[0], 1);
    check("midrst_valid", out_valid[0], 0);
    tick();
    check("midrst_valid2", out_valid[0], 0);
    issue(0, 4'd0, 32'h0, 16'h0, 32'h0, 1'b1, 5'd3, 32'h0000_0055);
    check("none_valid", out_valid[0], 1);
    check("none_data", out_wb_data[0], 32'h55);
    check("none_wb_en", out_wb_en[0], 1);
    check("none_wb_addr", out_wb_addr[0], 5'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
